// File: rtl/stereo_depth_engine_pkg.sv
// depth_pkg: shared status/state types and the depth ceiling helper for the stereo depth engine
package depth_pkg;
  typedef enum logic [1:0] {ST_OK, ST_ZERO_DISP, ST_BELOW_MIN, ST_CLAMPED} depth_status_t;
  typedef enum logic [1:0] {S_IDLE, S_DISP, S_DIV, S_OUT} eng_state_t;
  function automatic int unsigned depth_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/stereo_depth_engine_if.sv
// stereo_depth_engine_if: point-pair input stream and depth result stream of the engine
interface stereo_depth_engine_if #(
  parameter int X_W     = 12,
  parameter int DEPTH_W = 12,
  parameter int CH_W    = 2
);
  logic               s_valid_in;
  logic               s_ready_out;
  logic [X_W-1:0]     x_1_in;
  logic [X_W-1:0]     x_2_in;
  logic [CH_W-1:0]    s_chan_in;
  logic               m_valid_out;
  logic               m_ready_in;
  logic [DEPTH_W-1:0] depth_out;
  logic [CH_W-1:0]    m_chan_out;
  logic [1:0]         status_out;
  modport master (
    output s_valid_in, x_1_in, x_2_in, s_chan_in, m_ready_in,
    input  s_ready_out, m_valid_out, depth_out, m_chan_out, status_out
  );
  modport slave (
    input  s_valid_in, x_1_in, x_2_in, s_chan_in, m_ready_in,
    output s_ready_out, m_valid_out, depth_out, m_chan_out, status_out
  );
endinterface

// File: rtl/stereo_depth_engine_seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per cycle, MSB first
module seq_divider #(
  parameter int N_W = 12,
  parameter int D_W = 12
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           start_in,
  input  logic [N_W-1:0] num_in,
  input  logic [D_W-1:0] den_in,
  output logic           busy_out,
  output logic           done_out,
  output logic [N_W-1:0] quo_out
);
  localparam int C_W = $clog2(N_W + 1);
  logic [N_W-1:0] quo_q, quo_d;
  logic [D_W-1:0] rem_q, rem_d, den_q, den_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [D_W:0]   r_sh, diff;
  logic           ge;
  // shift in the next dividend bit, subtract when it fits; start reloads everything
  always_comb begin
    r_sh  = {rem_q, quo_q[N_W-1]};
    diff  = r_sh - {1'b0, den_q};
    ge    = r_sh >= {1'b0, den_q};
    quo_d = quo_q;
    rem_d = rem_q;
    den_d = den_q;
    cnt_d = cnt_q;
    if (start_in) begin
      quo_d = num_in;
      rem_d = '0;
      den_d = den_in;
      cnt_d = C_W'(N_W);
    end else if (cnt_q != '0) begin
      quo_d = {quo_q[N_W-2:0], ge};
      rem_d = ge ? diff[D_W-1:0] : r_sh[D_W-1:0];
      cnt_d = cnt_q - 1'b1;
    end
  end
  // divider state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
    end
  end
  // done marks the final iteration; the quotient it presents is the value being written this edge
  assign busy_out = cnt_q != '0;
  assign done_out = cnt_q == C_W'(1);
  assign quo_out  = quo_d;
endmodule

// File: rtl/stereo_depth_engine.sv
// stereo_depth_engine: depth = SCALE / |x_1 - x_2| with disparity gating, clamping and per-channel hold
module stereo_depth_engine
  import depth_pkg::*;
#(
  parameter int X_W             = 12,
  parameter int DEPTH_W         = 12,
  parameter int SCALE           = 2973,
  parameter int SCALE_W         = 12,
  parameter int MIN_DISP        = 2,
  parameter int NUM_CH          = 4,
  parameter int HOLD_ON_INVALID = 0
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  stereo_depth_engine_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [DEPTH_W-1:0] D_MAX = DEPTH_W'(depth_max(DEPTH_W));
  eng_state_t         state_q, state_d;
  logic [X_W-1:0]     x1_q, x1_d, x2_q, x2_d;
  logic [CH_W-1:0]    chan_q, chan_d, idx;
  logic               valid_q, valid_d, ready_q, ready_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  depth_status_t      status_q, status_d;
  logic [DEPTH_W-1:0] hold_q [NUM_CH];
  logic [DEPTH_W-1:0] hold_d [NUM_CH];
  logic [X_W-1:0]     disp;
  logic               gated, accept, div_start, div_busy, div_done, clamp;
  logic [SCALE_W-1:0] quo;
  assign disp   = x1_q >= x2_q ? x1_q - x2_q : x2_q - x1_q;
  assign gated  = 32'(disp) < MIN_DISP || disp == '0;
  assign accept = bus.s_valid_in && ready_q;
  assign idx    = 32'(chan_q) >= NUM_CH ? '0 : chan_q;
  assign clamp  = 32'(quo) > depth_max(DEPTH_W);
  seq_divider #(.N_W(SCALE_W), .D_W(X_W)) u_div (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start_in (div_start),
    .num_in   (SCALE_W'(SCALE)),
    .den_in   (disp),
    .busy_out (div_busy),
    .done_out (div_done),
    .quo_out  (quo)
  );
  // state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // next state: gated pairs skip the divider
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_DISP : S_IDLE;
      S_DISP:  state_d = gated ? S_OUT : S_DIV;
      S_DIV:   state_d = div_done ? S_OUT : S_DIV;
      S_OUT:   state_d = bus.m_ready_in ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
  end
  // datapath: latch the pair, resolve gated or divided depth, update the channel's last good depth
  always_comb begin
    x1_d      = x1_q;
    x2_d      = x2_q;
    chan_d    = chan_q;
    depth_d   = depth_q;
    status_d  = status_q;
    hold_d    = hold_q;
    valid_d   = state_d == S_OUT;
    ready_d   = state_d == S_IDLE;
    div_start = state_q == S_DISP && !gated;
    if (state_q == S_IDLE && accept) begin
      x1_d   = bus.x_1_in;
      x2_d   = bus.x_2_in;
      chan_d = bus.s_chan_in;
    end
    if (state_q == S_DISP && gated) begin
      depth_d  = HOLD_ON_INVALID != 0 ? hold_q[idx] : D_MAX;
      status_d = disp == '0 ? ST_ZERO_DISP : ST_BELOW_MIN;
    end
    if (state_q == S_DIV && div_done) begin
      depth_d     = clamp ? D_MAX : DEPTH_W'(quo);
      status_d    = clamp ? ST_CLAMPED : ST_OK;
      hold_d[idx] = depth_d;
    end
  end
  // job and output registers; reset drops any job in flight
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x1_q     <= '0;
      x2_q     <= '0;
      chan_q   <= '0;
      depth_q  <= '0;
      status_q <= ST_OK;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      hold_q   <= '{default: D_MAX};
    end else begin
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      chan_q   <= chan_d;
      depth_q  <= depth_d;
      status_q <= status_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      hold_q   <= hold_d;
    end
  end
  assign bus.s_ready_out = ready_q;
  assign bus.m_valid_out = valid_q;
  assign bus.depth_out   = depth_q;
  assign bus.m_chan_out  = chan_q;
  assign bus.status_out  = status_q;
endmodule

// File: tb/tb_stereo_depth_engine.sv
// tb_stereo_depth_engine: directed vectors against default, hold-enabled and 8-bit-depth engines
module tb_stereo_depth_engine;
  logic        clk, rst_n, s_valid, m_ready;
  logic [11:0] x1, x2;
  logic [1:0]  chan;
  int          sel, n_cmp, n_err, lat;
  logic        o_ready, o_valid;
  logic [11:0] o_depth;
  logic [1:0]  o_chan, o_status;
  stereo_depth_engine_if #(.X_W(12), .DEPTH_W(12), .CH_W(2)) if0 ();
  stereo_depth_engine_if #(.X_W(12), .DEPTH_W(12), .CH_W(2)) if1 ();
  stereo_depth_engine_if #(.X_W(12), .DEPTH_W(8), .CH_W(2)) if2 ();
  stereo_depth_engine u0 (.clk_in(clk), .rst_n_in(rst_n), .bus(if0.slave));
  stereo_depth_engine #(.HOLD_ON_INVALID(1)) u1 (.clk_in(clk), .rst_n_in(rst_n), .bus(if1.slave));
  stereo_depth_engine #(.DEPTH_W(8), .MIN_DISP(1)) u2 (.clk_in(clk), .rst_n_in(rst_n), .bus(if2.slave));
  assign if0.s_valid_in = s_valid && sel == 0;
  assign if1.s_valid_in = s_valid && sel == 1;
  assign if2.s_valid_in = s_valid && sel == 2;
  assign if0.x_1_in = x1;
  assign if1.x_1_in = x1;
  assign if2.x_1_in = x1;
  assign if0.x_2_in = x2;
  assign if1.x_2_in = x2;
  assign if2.x_2_in = x2;
  assign if0.s_chan_in = chan;
  assign if1.s_chan_in = chan;
  assign if2.s_chan_in = chan;
  assign if0.m_ready_in = m_ready;
  assign if1.m_ready_in = m_ready;
  assign if2.m_ready_in = m_ready;
  assign o_ready  = sel == 0 ? if0.s_ready_out : sel == 1 ? if1.s_ready_out : if2.s_ready_out;
  assign o_valid  = sel == 0 ? if0.m_valid_out : sel == 1 ? if1.m_valid_out : if2.m_valid_out;
  assign o_depth  = sel == 0 ? if0.depth_out : sel == 1 ? if1.depth_out : 12'(if2.depth_out);
  assign o_chan   = sel == 0 ? if0.m_chan_out : sel == 1 ? if1.m_chan_out : if2.m_chan_out;
  assign o_status = sel == 0 ? if0.status_out : sel == 1 ? if1.status_out : if2.status_out;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input int k, input int a, input int b, input int c);
    int t = 0;
    sel = k;
    #1;
    while (!o_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("accept_ready", 32'(o_ready), 1);
    x1 = 12'(a);
    x2 = 12'(b);
    chan = 2'(c);
    s_valid = 1;
    @(posedge clk);
    #1;
    s_valid = 0;
  endtask
  task automatic wait_valid(output int l);
    l = 1;
    while (!o_valid && l < 40) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  task automatic run(input string tag, input int k, input int a, input int b, input int c,
                     input int ed, input int es, input int el);
    send(k, a, b, c);
    wait_valid(lat);
    check({tag, "_lat"}, lat, el);
    check({tag, "_depth"}, 32'(o_depth), ed);
    check({tag, "_status"}, 32'(o_status), es);
    check({tag, "_chan"}, 32'(o_chan), c);
    @(posedge clk);
    #1;
    check({tag, "_drop"}, 32'(o_valid), 0);
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 0;
    s_valid = 0;
    m_ready = 1;
    sel = 0;
    x1 = 0;
    x2 = 0;
    chan = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_depth", 32'(o_depth), 0);
    check("rst_status", 32'(o_status), 0);
    check("rst_chan", 32'(o_chan), 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(o_ready), 1);
    run("div60", 0, 700, 640, 1, 49, 0, 14);
    run("div60_swap", 0, 640, 700, 1, 49, 0, 14);
    run("zero", 0, 300, 300, 0, 4095, 1, 2);
    run("below", 0, 301, 300, 2, 4095, 2, 2);
    run("at_min", 0, 0, 2, 3, 1486, 0, 14);
    run("max_disp", 0, 4095, 0, 3, 0, 0, 14);
    m_ready = 0;
    send(0, 700, 640, 1);
    wait_valid(lat);
    check("bp_lat", lat, 14);
    for (int i = 0; i < 10; i++) begin
      x1 = 900;
      x2 = 100;
      chan = 3;
      s_valid = 1;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(o_valid), 1);
      check("bp_depth", 32'(o_depth), 49);
      check("bp_chan", 32'(o_chan), 1);
      check("bp_status", 32'(o_status), 0);
      check("bp_ready", 32'(o_ready), 0);
    end
    s_valid = 0;
    m_ready = 1;
    @(posedge clk);
    #1;
    check("bp_done_valid", 32'(o_valid), 0);
    check("bp_idle_ready", 32'(o_ready), 1);
    run("hold_good", 1, 700, 640, 2, 49, 0, 14);
    run("hold_zero", 1, 300, 300, 2, 49, 1, 2);
    run("hold_below", 1, 301, 300, 2, 49, 2, 2);
    run("hold_fresh", 1, 300, 300, 3, 4095, 1, 2);
    run("n8_clamp", 2, 5, 0, 1, 255, 3, 14);
    run("n8_ok", 2, 12, 0, 2, 247, 0, 14);
    run("n8_zero", 2, 0, 0, 0, 255, 1, 2);
    run("n8_disp1", 2, 1, 0, 3, 255, 3, 14);
    send(0, 700, 640, 1);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_ready", 32'(o_ready), 0);
    check("mid_rst_depth", 32'(o_depth), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("mid_rel_ready", 32'(o_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    check("no_stale_valid", 32'(o_valid), 0);
    check("no_stale_depth", 32'(o_depth), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
